vector_mem_sequencer: RTL and testbench
=======================================

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameters SHALL be: LANES, default 4, vector lane count; DATA_WIDTH, default 8, lane element width; ADDR_WIDTH, default 32, word-address width.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- startM  in  1  M-stage vector memory op valid; held stable while stallM=1
- writeToMemoryEnableM  in  1  1=VSTR, 0=VLDR
- baseAddrM  in  ADDR_WIDTH  lane-0 address from scalar ALU
- storeDataM  in  LANES*DATA_WIDTH  store vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- memReadData  in  DATA_WIDTH  data memory read port; valid 1 cycle after memAddr
- memAddr  out  ADDR_WIDTH  data memory address
- memWriteData  out  DATA_WIDTH  data memory write data
- memWriteEnable  out  1  data memory write strobe
- loadDataM  out  LANES*DATA_WIDTH  assembled load vector, same lane packing
- stallM  out  1  freeze IF..M pipeline registers
- doneM  out  1  one-cycle completion pulse

Function
REQ-004 FSM states SHALL be IDLE, STORE, LOAD, LOAD_LAST, DONE.
REQ-005 IDLE: startM=1 and writeToMemoryEnableM=1 -> STORE; startM=1 and writeToMemoryEnableM=0 -> LOAD; lane counter cleared to 0; otherwise stay.
REQ-006 stallM SHALL be combinational: 1 in STORE, LOAD, LOAD_LAST, and in IDLE when startM=1; 0 in DONE and idle-without-start.
REQ-007 STORE: per cycle, memWriteEnable=1, memAddr=baseAddrM+k, memWriteData=lane k of storeDataM, k = lane counter; k increments; after k=LANES-1 -> DONE.
REQ-008 LOAD: per cycle, memAddr=baseAddrM+k, memWriteEnable=0; when k>0, memReadData SHALL be captured into loadDataM lane k-1; after k=LANES-1 -> LOAD_LAST.
REQ-009 LOAD_LAST: memReadData captured into lane LANES-1; -> DONE.
REQ-010 DONE: doneM=1 for exactly one cycle, stallM=0; startM ignored (still the completing op); -> IDLE.
REQ-011 Latency from start cycle (IDLE, startM=1): VSTR DONE at cycle LANES+1; VLDR DONE at cycle LANES+2.
REQ-012 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (wrap, no error).
REQ-013 memWriteEnable SHALL be 0 in every state other than STORE; memAddr and memWriteData SHALL be 0 outside STORE/LOAD.
REQ-014 loadDataM SHALL hold its value from DONE until the next LOAD capture; STORE SHALL not modify it.
REQ-015 Back-to-back ops SHALL incur one IDLE cycle between DONE and the next start.

Reset
REQ-016 rst=1 SHALL immediately force state IDLE, lane counter 0, loadDataM 0, doneM 0, memWriteEnable 0, regardless of clock.
REQ-017 Reset mid-operation SHALL abort it: no further writes, partial loadDataM discarded (zeroed), no doneM pulse.
REQ-018 After reset release, the first rising edge with startM=1 in IDLE SHALL begin a new op normally.

Structure
REQ-019 Package vector_mem_pkg SHALL hold the state enum type and LANES/DATA_WIDTH/ADDR_WIDTH defaults shared with the datapath.
REQ-020 One sub-module lane_counter (clear, enable, terminal-count flag at LANES-1) SHALL be instantiated; all else in vector_mem_sequencer.

Verification (LANES=4, DATA_WIDTH=8)
REQ-021 VSTR, baseAddrM=0x100, storeDataM=0x44332211 -> writes 0x11@0x100, 0x22@0x101, 0x33@0x102, 0x44@0x103 on cycles 1-4; stallM=1 cycles 0-4; doneM=1 cycle 5.
REQ-022 VLDR, baseAddrM=0x20, memory 0xA0..0xA3 at 0x20..0x23 -> loadDataM=0xA3A2A1A0 at cycle 6 with doneM=1; no writes.
REQ-023 VSTR, baseAddrM=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-024 rst asserted after two STORE writes -> memWriteEnable=0 immediately, exactly two writes total, stallM=0, no doneM, state IDLE.
REQ-025 VSTR then VLDR back-to-back with startM held high -> DONE does not restart; VLDR starts at the IDLE cycle after DONE; both complete with correct data.
REQ-026 startM=0 for 20 cycles -> memWriteEnable, stallM, doneM stay 0.

Source files
------------

// File: rtl/vector_mem_pkg.sv
// Shared types and default geometry for the vector memory sequencer.
// The lane datapath and the FSM use the same defaults.
package vector_mem_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_LAST = 3'd3,
        DONE      = 3'd4
    } seqState_t;

endpackage

// File: rtl/vector_mem_sequencer_lane_counter.sv
// Lane index counter for the vector memory sequencer.
// Wraps to zero after the last lane and flags the last lane.
module lane_counter
    import vector_mem_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int CW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          lastLane
);

    assign lastLane = (count == CW'(LANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= lastLane ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Sequences a vector load/store as one element access per cycle
// on a single-ported data memory while stalling the pipeline.
module vector_mem_sequencer
    import vector_mem_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        startM,
    input  logic                        writeToMemoryEnableM,
    input  logic [ADDR_WIDTH-1:0]       baseAddrM,
    input  logic [LANES*DATA_WIDTH-1:0] storeDataM,
    input  logic [DATA_WIDTH-1:0]       memReadData,
    output logic [ADDR_WIDTH-1:0]       memAddr,
    output logic [DATA_WIDTH-1:0]       memWriteData,
    output logic                        memWriteEnable,
    output logic [LANES*DATA_WIDTH-1:0] loadDataM,
    output logic                        stallM,
    output logic                        doneM
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    seqState_t     state;
    seqState_t     stateNext;
    logic [CW-1:0] lane;
    logic          lastLane;
    logic          laneActive;
    logic          capture;
    logic [CW-1:0] captureLane;

    lane_counter #(
        .LANES (LANES),
        .CW    (CW)
    ) uLaneCounter (
        .clk      (clk),
        .rst      (rst),
        .clear    (!laneActive),
        .enable   (laneActive),
        .count    (lane),
        .lastLane (lastLane)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (startM) begin
                    stateNext = writeToMemoryEnableM ? STORE : LOAD;
                end
            end
            STORE: begin
                if (lastLane) begin
                    stateNext = DONE;
                end
            end
            LOAD: begin
                if (lastLane) begin
                    stateNext = LOAD_LAST;
                end
            end
            LOAD_LAST: stateNext = DONE;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    assign laneActive     = (state == STORE) || (state == LOAD);
    assign memWriteEnable = (state == STORE);
    assign doneM          = (state == DONE);

    assign stallM = laneActive
                 || (state == LOAD_LAST)
                 || ((state == IDLE) && startM);

    assign memAddr = laneActive
                   ? baseAddrM + ADDR_WIDTH'(lane)
                   : '0;

    assign memWriteData = memWriteEnable
                        ? storeDataM[lane*DATA_WIDTH +: DATA_WIDTH]
                        : '0;

    // Read data lags the address by one cycle, so lane k-1 lands while k is issued.
    assign capture = ((state == LOAD) && (lane != '0))
                  || (state == LOAD_LAST);

    assign captureLane = (state == LOAD_LAST)
                       ? CW'(LANES - 1)
                       : lane - CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadDataM <= '0;
        end else if (capture) begin
            loadDataM[captureLane*DATA_WIDTH +: DATA_WIDTH] <= memReadData;
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a byte memory model.
// Stores land in the model so later loads can read them back.
module tb_vector_mem_sequencer;

    logic        clk;
    logic        rst;
    logic        startM;
    logic        writeToMemoryEnableM;
    logic [31:0] baseAddrM;
    logic [31:0] storeDataM;
    logic [7:0]  memReadData;
    logic [31:0] memAddr;
    logic [7:0]  memWriteData;
    logic        memWriteEnable;
    logic [31:0] loadDataM;
    logic        stallM;
    logic        doneM;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;

    logic [7:0]  mem [0:255];
    logic [31:0] wrAddr [$];
    logic [7:0]  wrData [$];

    vector_mem_sequencer #(
        .LANES      (4),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (32)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .startM               (startM),
        .writeToMemoryEnableM (writeToMemoryEnableM),
        .baseAddrM            (baseAddrM),
        .storeDataM           (storeDataM),
        .memReadData          (memReadData),
        .memAddr              (memAddr),
        .memWriteData         (memWriteData),
        .memWriteEnable       (memWriteEnable),
        .loadDataM            (loadDataM),
        .stallM               (stallM),
        .doneM                (doneM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] readModel(input logic [31:0] a);
        if (a >= 32'h20 && a <= 32'h23) begin
            return 8'hA0 + 8'(a - 32'h20);
        end
        return mem[a[7:0]];
    endfunction

    always @(posedge clk) begin
        memReadData <= readModel(memAddr);
        if (memWriteEnable) begin
            mem[memAddr[7:0]] <= memWriteData;
            wrAddr.push_back(memAddr);
            wrData.push_back(memWriteData);
        end
        if (doneM) doneCount++;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic runOp(input logic        we,
                         input logic [31:0] base,
                         input logic [31:0] data,
                         input int          expLat,
                         output logic [31:0] ldAtDone);
        int lat;
        bit seen;
        wrAddr.delete();
        wrData.delete();
        @(negedge clk);
        startM = 1'b1;
        writeToMemoryEnableM = we;
        baseAddrM = base;
        storeDataM = data;
        #1;
        check("stallStart", 64'(stallM), 64'd1);
        lat = 0;
        seen = 0;
        ldAtDone = '0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (doneM) begin
                seen = 1;
                lat = c;
                ldAtDone = loadDataM;
            end else begin
                check("stallBusy", 64'(stallM), 64'd1);
            end
        end
        check("doneSeen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(expLat));
        check("stallAtDone", 64'(stallM), 64'd0);
        check("weAtDone", 64'(memWriteEnable), 64'd0);
        startM = 1'b0;
        @(negedge clk);
        #1;
        check("doneOneCycle", 64'(doneM), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ld;
        logic [31:0] expA [4];
        logic [7:0]  expD [4];
        bit          noisy;
        int          doneBase;
        int          lat;
        bit          seen;

        rst = 1'b1;
        startM = 1'b0;
        writeToMemoryEnableM = 1'b0;
        baseAddrM = '0;
        storeDataM = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rstLoad", 64'(loadDataM), 64'd0);
        check("rstDone", 64'(doneM), 64'd0);
        check("rstWe", 64'(memWriteEnable), 64'd0);
        check("rstStall", 64'(stallM), 64'd0);
        check("rstAddr", 64'(memAddr), 64'd0);
        rst = 1'b0;

        // idle quiet
        noisy = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (memWriteEnable || stallM || doneM) noisy = 1;
        end
        check("idleQuiet", 64'(noisy), 64'd0);
        check("idleNoDone", 64'(doneCount), 64'd0);

        // VLDR from 0x20
        runOp(1'b0, 32'h20, 32'h0, 6, ld);
        check("ldData", 64'(ld), 64'hA3A2A1A0);
        check("ldNoWrites", 64'(wrAddr.size()), 64'd0);

        // VSTR to 0x100
        runOp(1'b1, 32'h100, 32'h44332211, 5, ld);
        expA = '{32'h100, 32'h101, 32'h102, 32'h103};
        expD = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("stNumWrites", 64'(wrAddr.size()), 64'd4);
        for (int i = 0; i < 4 && i < wrAddr.size(); i++) begin
            check($sformatf("stAddr%0d", i), 64'(wrAddr[i]), 64'(expA[i]));
            check($sformatf("stData%0d", i), 64'(wrData[i]), 64'(expD[i]));
        end
        check("ldHeldAfterSt", 64'(loadDataM), 64'hA3A2A1A0);

        // address wrap
        runOp(1'b1, 32'hFFFF_FFFE, 32'h0D0C0B0A, 5, ld);
        expA = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        check("wrapNumWrites", 64'(wrAddr.size()), 64'd4);
        for (int i = 0; i < 4 && i < wrAddr.size(); i++) begin
            check($sformatf("wrapAddr%0d", i), 64'(wrAddr[i]), 64'(expA[i]));
        end

        // reset mid-store after two writes
        wrAddr.delete();
        wrData.delete();
        doneBase = doneCount;
        @(negedge clk);
        startM = 1'b1;
        writeToMemoryEnableM = 1'b1;
        baseAddrM = 32'h200;
        storeDataM = 32'h77665544;
        repeat (3) @(negedge clk);
        #1;
        check("abortPreWe", 64'(memWriteEnable), 64'd1);
        rst = 1'b1;
        startM = 1'b0;
        #1;
        check("abortWe", 64'(memWriteEnable), 64'd0);
        check("abortStall", 64'(stallM), 64'd0);
        check("abortDone", 64'(doneM), 64'd0);
        check("abortLoadZero", 64'(loadDataM), 64'd0);
        check("abortAddr", 64'(memAddr), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("abortNumWrites", 64'(wrAddr.size()), 64'd2);
        if (wrData.size() == 2) begin
            check("abortData0", 64'(wrData[0]), 64'h44);
            check("abortData1", 64'(wrData[1]), 64'h55);
        end
        check("abortNoDone", 64'(doneCount - doneBase), 64'd0);
        check("abortIdle", 64'(stallM), 64'd0);

        // back-to-back VSTR then VLDR with startM held high
        wrAddr.delete();
        wrData.delete();
        @(negedge clk);
        startM = 1'b1;
        writeToMemoryEnableM = 1'b1;
        baseAddrM = 32'h40;
        storeDataM = 32'hDDCCBBAA;
        lat = 0;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (doneM) begin
                seen = 1;
                lat = c;
            end
        end
        check("b2bStLatency", 64'(lat), 64'd5);
        writeToMemoryEnableM = 1'b0;
        @(negedge clk);
        #1;
        check("b2bNoRestart", 64'(doneM), 64'd0);
        check("b2bIdleStall", 64'(stallM), 64'd1);
        check("b2bIdleWe", 64'(memWriteEnable), 64'd0);
        lat = 0;
        seen = 0;
        ld = '0;
        for (int c = 7; c <= 30 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (c == 7) check("b2bLdAddr", 64'(memAddr), 64'h40);
            if (doneM) begin
                seen = 1;
                lat = c;
                ld = loadDataM;
            end
        end
        startM = 1'b0;
        check("b2bLdDoneCycle", 64'(lat), 64'd12);
        check("b2bLdData", 64'(ld), 64'hDDCCBBAA);
        check("b2bNumWrites", 64'(wrAddr.size()), 64'd4);
        if (wrAddr.size() == 4) begin
            check("b2bLastAddr", 64'(wrAddr[3]), 64'h43);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
